// File: rtl/control_unit_multiciclo_pkg.sv
// Shared opcodes, step encodings and sizes for the multicycle control unit.
// The optional trap is enabled with the CTRL_ILLEGAL_TRAP_EN macro.
package ctrl_multiciclo_pkg;

  localparam int SEL_W  = 3;
  localparam int N_REGS = 8;
  localparam int IR_W   = 9;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_t;

  // Opcodes with the top bit set have no datapath meaning.
  function automatic logic is_illegal(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/control_unit_multiciclo_dec3to8.sv
// Register-field to one-hot decoder with enable.
// All-zero output when disabled.
module dec3to8
  import ctrl_multiciclo_pkg::*;
#(
  parameter int SW = SEL_W,
  parameter int NO = N_REGS
) (
  input  logic [SW-1:0] sel,
  input  logic          en,
  output logic [NO-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NO; i++) begin
      if (en && (sel == SW'(i))) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/control_unit_multiciclo.sv
// Multicycle processor control FSM (T0..T3 sequencing, bus/ALU enables).
// Optional illegal-opcode trap: define CTRL_ILLEGAL_TRAP_EN.
module control_unit_multiciclo
  import ctrl_multiciclo_pkg::*;
#(
  parameter int N_REGS = ctrl_multiciclo_pkg::N_REGS,
  parameter int SEL_W  = ctrl_multiciclo_pkg::SEL_W,
  parameter int IR_W   = ctrl_multiciclo_pkg::IR_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Run,
  input  logic [IR_W-1:0]   IR,
  output logic              IRin,
  output logic [N_REGS-1:0] Rin,
  output logic [N_REGS-1:0] Rout,
  output logic              DINout,
  output logic              Gout,
  output logic              Ain,
  output logic              Gin,
  output logic              AddSub,
  output logic              Done,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic              Illegal,
`endif
  output logic [1:0]        Tstep
);

  tstep_t tstep_q, tstep_d;

  logic [2:0]       opcode;
  logic [SEL_W-1:0] rx, ry;
  logic [N_REGS-1:0] x_oh, y_oh;

  logic irin_c, din_c, gout_c, ain_c, gin_c;
  logic addsub_c, done_c;
  logic rx_in, rx_out, ry_out;

  assign opcode = IR[IR_W-1 -: 3];
  assign rx     = IR[2*SEL_W-1 -: SEL_W];
  assign ry     = IR[SEL_W-1:0];

  always_ff @(posedge Clock) begin
    if (Reset) tstep_q <= T0;
    else       tstep_q <= tstep_d;
  end

  always_comb begin
    tstep_d  = tstep_q;
    irin_c   = 1'b0;
    din_c    = 1'b0;
    gout_c   = 1'b0;
    ain_c    = 1'b0;
    gin_c    = 1'b0;
    addsub_c = 1'b0;
    done_c   = 1'b0;
    rx_in    = 1'b0;
    rx_out   = 1'b0;
    ry_out   = 1'b0;
    unique case (tstep_q)
      T0: begin
        if (Run) begin
          irin_c  = 1'b1;
          din_c   = 1'b1;
          tstep_d = T1;
        end
      end
      T1: begin
        case (opcode)
          OP_MV: begin
            ry_out  = 1'b1;
            rx_in   = 1'b1;
            done_c  = 1'b1;
            tstep_d = T0;
          end
          OP_MVI: begin
            din_c   = 1'b1;
            rx_in   = 1'b1;
            done_c  = 1'b1;
            tstep_d = T0;
          end
          OP_ADD, OP_SUB: begin
            rx_out  = 1'b1;
            ain_c   = 1'b1;
            tstep_d = T2;
          end
          default: begin
            done_c  = 1'b1;
            tstep_d = T0;
          end
        endcase
      end
      T2: begin
        ry_out   = 1'b1;
        gin_c    = 1'b1;
        addsub_c = (opcode == OP_SUB);
        tstep_d  = T3;
      end
      T3: begin
        gout_c  = 1'b1;
        rx_in   = 1'b1;
        done_c  = 1'b1;
        tstep_d = T0;
      end
      default: tstep_d = T0;
    endcase
  end

  dec3to8 #(.SW(SEL_W), .NO(N_REGS)) u_dec_x (
    .sel    (rx),
    .en     (rx_in | rx_out),
    .onehot (x_oh)
  );

  dec3to8 #(.SW(SEL_W), .NO(N_REGS)) u_dec_y (
    .sel    (ry),
    .en     (ry_out),
    .onehot (y_oh)
  );

  // Reset overrides every decoded output, including the step probe.
  always_comb begin
    IRin   = irin_c & ~Reset;
    DINout = din_c & ~Reset;
    Gout   = gout_c & ~Reset;
    Ain    = ain_c & ~Reset;
    Gin    = gin_c & ~Reset;
    AddSub = addsub_c & ~Reset;
    Done   = done_c & ~Reset;
    Rin    = (rx_in ? x_oh : '0) & {N_REGS{~Reset}};
    Rout   = ((rx_out ? x_oh : '0) | y_oh)
             & {N_REGS{~Reset}};
    Tstep  = Reset ? 2'd0 : tstep_q;
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic sticky_q;
  logic ill_t1;

  assign ill_t1 = (tstep_q == T1) && is_illegal(opcode);

  always_ff @(posedge Clock) begin
    if (Reset)       sticky_q <= 1'b0;
    else if (ill_t1) sticky_q <= 1'b1;
  end

  assign Illegal = (ill_t1 | sticky_q) & ~Reset;
`endif

endmodule

// File: tb/tb_control_unit_multiciclo.sv
// Directed-vector bench for control_unit_multiciclo.
// Checks per-cycle outputs of every opcode, reset abort and trap.
module tb_control_unit_multiciclo;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Run;
  logic [8:0] IR;
  logic       IRin, DINout, Gout, Ain, Gin, AddSub, Done;
  logic [7:0] Rin, Rout;
  logic [1:0] Tstep;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic       Illegal;
`endif

  int total = 0;
  int bad   = 0;
  int dones = 0;

  always #5 Clock = ~Clock;

  control_unit_multiciclo dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Run     (Run),
    .IR      (IR),
    .IRin    (IRin),
    .Rin     (Rin),
    .Rout    (Rout),
    .DINout  (DINout),
    .Gout    (Gout),
    .Ain     (Ain),
    .Gin     (Gin),
    .AddSub  (AddSub),
    .Done    (Done),
`ifdef CTRL_ILLEGAL_TRAP_EN
    .Illegal (Illegal),
`endif
    .Tstep   (Tstep)
  );

  // {IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done}
  function automatic logic [22:0] pack(
    input logic irin, input logic [7:0] rin,
    input logic [7:0] rout, input logic din,
    input logic gout, input logic ain, input logic gin,
    input logic addsub, input logic done);
    return {irin, rin, rout, din, gout, ain, gin, addsub, done};
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic expect_cyc(input string tag,
                            input logic [1:0] ts,
                            input logic [22:0] v);
    int srcs;
    #1;
    srcs = $countones(Rout) + int'(DINout) + int'(Gout);
    check({tag, ".tstep"}, 32'(Tstep), 32'(ts));
    check({tag, ".outs"},
          32'({IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done}),
          32'(v));
    check({tag, ".bus1"}, 32'(srcs <= 1), 32'd1);
    if (Done) dones++;
  endtask

  localparam logic [22:0] IDLE  = 23'd0;
  localparam logic [22:0] FETCH =
    23'b1_00000000_00000000_1_0_0_0_0_0;

  initial begin
    Reset = 1'b1;
    Run   = 1'b1;
    IR    = 9'b000_000_001;
    tick();
    expect_cyc("rst", 2'd0, IDLE);
`ifdef CTRL_ILLEGAL_TRAP_EN
    check("rst.ill", 32'(Illegal), 32'd0);
`endif
    tick();
    Reset = 1'b0;
    Run   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_cyc("idle", 2'd0, IDLE);
      tick();
    end

    // mv R0,R1
    Run = 1'b1;
    IR  = 9'b000_000_001;
    expect_cyc("mv.t0", 2'd0, FETCH);
    tick();
    Run = 1'b0;
    expect_cyc("mv.t1", 2'd1,
      pack(0, 8'h01, 8'h02, 0, 0, 0, 0, 0, 1));
    tick();
    expect_cyc("mv.end", 2'd0, IDLE);

    // mvi R0,#5
    Run = 1'b1;
    IR  = 9'b001_000_001;
    expect_cyc("mvi.t0", 2'd0, FETCH);
    tick();
    Run = 1'b0;
    expect_cyc("mvi.t1", 2'd1,
      pack(0, 8'h01, 8'h00, 1, 0, 0, 0, 0, 1));
    tick();
    expect_cyc("mvi.end", 2'd0, IDLE);

    // add R2,R3 then sub R2,R3, Run held high
    dones = 0;
    Run = 1'b1;
    IR  = 9'b010_010_011;
    expect_cyc("add.t0", 2'd0, FETCH);
    tick();
    expect_cyc("add.t1", 2'd1,
      pack(0, 8'h00, 8'h04, 0, 0, 1, 0, 0, 0));
    tick();
    expect_cyc("add.t2", 2'd2,
      pack(0, 8'h00, 8'h08, 0, 0, 0, 1, 0, 0));
    tick();
    expect_cyc("add.t3", 2'd3,
      pack(0, 8'h04, 8'h00, 0, 1, 0, 0, 0, 1));
    tick();
    IR = 9'b011_010_011;
    expect_cyc("sub.t0", 2'd0, FETCH);
    tick();
    expect_cyc("sub.t1", 2'd1,
      pack(0, 8'h00, 8'h04, 0, 0, 1, 0, 0, 0));
    tick();
    expect_cyc("sub.t2", 2'd2,
      pack(0, 8'h00, 8'h08, 0, 0, 0, 1, 1, 0));
    tick();
    expect_cyc("sub.t3", 2'd3,
      pack(0, 8'h04, 8'h00, 0, 1, 0, 0, 0, 1));
    check("b2b.dones", 32'(dones), 32'd2);
    tick();
    Run = 1'b0;
    expect_cyc("b2b.end", 2'd0, IDLE);

    // add aborted by reset in T2
    Run = 1'b1;
    IR  = 9'b010_010_011;
    expect_cyc("abt.t0", 2'd0, FETCH);
    tick();
    Run = 1'b0;
    expect_cyc("abt.t1", 2'd1,
      pack(0, 8'h00, 8'h04, 0, 0, 1, 0, 0, 0));
    tick();
    Reset = 1'b1;
    expect_cyc("abt.rst", 2'd0, IDLE);
    tick();
    Reset = 1'b0;
    expect_cyc("abt.idle", 2'd0, IDLE);

    // mv R3,R3 after the abort
    Run = 1'b1;
    IR  = 9'b000_011_011;
    expect_cyc("mv33.t0", 2'd0, FETCH);
    tick();
    Run = 1'b0;
    expect_cyc("mv33.t1", 2'd1,
      pack(0, 8'h08, 8'h08, 0, 0, 0, 0, 0, 1));
    tick();
    expect_cyc("mv33.end", 2'd0, IDLE);

    // opcode 101
`ifdef CTRL_ILLEGAL_TRAP_EN
    check("ill.pre", 32'(Illegal), 32'd0);
`endif
    Run = 1'b1;
    IR  = 9'b101_000_000;
    expect_cyc("ill.t0", 2'd0, FETCH);
    tick();
    Run = 1'b0;
    expect_cyc("ill.t1", 2'd1,
      pack(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1));
`ifdef CTRL_ILLEGAL_TRAP_EN
    check("ill.t1.flag", 32'(Illegal), 32'd1);
`endif
    tick();
    IR = 9'b000_000_001;
    expect_cyc("ill.end", 2'd0, IDLE);
`ifdef CTRL_ILLEGAL_TRAP_EN
    check("ill.sticky", 32'(Illegal), 32'd1);
`endif
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    expect_cyc("ill.clr", 2'd0, IDLE);
`ifdef CTRL_ILLEGAL_TRAP_EN
    check("ill.cleared", 32'(Illegal), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
